// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D-cache to cacheline-adaptor arbiter.
package cache_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker, purely combinational; on contention the requester
// that did not win last time is chosen.
module arb_rr2
  import cache_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  requester_t last_grant,
  output requester_t grant,
  output logic       valid
);

  always_comb begin
    valid = req_i | req_d;
    if (req_i && req_d) begin
      grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      grant = REQ_D;
    end else begin
      grant = REQ_I;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cacheline adaptor between I- and D-cache: grant registered 1 cycle after request,
// response pulsed 1 cycle after mem_resp, then one RELEASE cycle; losers simply wait holding their request.
module cache_arbiter #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  import cache_arb_pkg::*;

  arb_state_t state, state_nxt;
  requester_t last_grant;
  requester_t rr_grant;
  logic       rr_valid;

  arb_rr2 u_rr (
    .req_i      (i_read | i_write),
    .req_d      (d_read | d_write),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .valid      (rr_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rr_valid) state_nxt = BUSY;
      BUSY:    if (mem_resp) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last_grant doubles as the owner of the in-flight transfer while BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= REQ_D;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_resp      <= 1'b0;
      d_resp      <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_valid) begin
            last_grant <= rr_grant;
            if (rr_grant == REQ_I) begin
              mem_address <= i_address;
              mem_wdata   <= i_wdata;
              mem_read    <= i_read;
              mem_write   <= i_write & ~i_read;
            end else begin
              mem_address <= d_address;
              mem_wdata   <= d_wdata;
              mem_read    <= d_read;
              mem_write   <= d_write & ~d_read;
            end
          end
        end
        BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (last_grant == REQ_I) begin
              i_resp <= 1'b1;
              if (mem_read) i_rdata <= mem_rdata;
            end else begin
              d_resp <= 1'b1;
              if (mem_read) d_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with an expected-transaction queue and a simple adaptor model.
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic [AW-1:0] i_address, d_address, mem_address;
  logic          i_read, i_write, d_read, d_write;
  logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_resp, d_resp, mem_read, mem_write, mem_resp;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_address   (i_address),
    .i_read      (i_read),
    .i_write     (i_write),
    .i_wdata     (i_wdata),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_address   (d_address),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  typedef struct {
    bit            is_d;
    bit            rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t          exp_q[$];
  txn_t          cur;
  int            compared   = 0;
  int            mismatched = 0;
  int            i_resp_cnt = 0;
  int            d_resp_cnt = 0;
  logic [LW-1:0] exp_i_rdata = '0;
  logic [LW-1:0] exp_d_rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (i_resp) i_resp_cnt++;
    if (d_resp) d_resp_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic txn_t mk(bit is_d, bit rd, logic [AW-1:0] a, logic [LW-1:0] w);
    txn_t t;
    t.is_d  = is_d;
    t.rd    = rd;
    t.addr  = a;
    t.wdata = w;
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    exp_q.delete();
  endtask

  // Waits for the adaptor request to rise and checks it against the next expected transaction.
  task automatic wait_grant(output int low_seen);
    bit got = 1'b0;
    low_seen = 0;
    cur = exp_q.pop_front();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        got = 1'b1;
        break;
      end
      low_seen++;
    end
    chk("grant_seen", LW'(got), LW'(1));
    if (got) begin
      chk("mem_address", LW'(mem_address), LW'(cur.addr));
      chk("mem_op", LW'({mem_read, mem_write}), LW'({cur.rd, !cur.rd}));
      if (!cur.rd) chk("mem_wdata", mem_wdata, cur.wdata);
    end
  endtask

  // Adaptor model: keeps request for lat cycles total, then pulses mem_resp with line.
  task automatic finish(input int lat, input logic [LW-1:0] line, input bit drop);
    bit stable = 1'b1;
    int hi = 1;
    for (int n = 1; n < lat; n++) begin
      @(negedge clk);
      if (mem_address !== cur.addr || mem_read !== cur.rd || mem_write !== !cur.rd ||
          (!cur.rd && mem_wdata !== cur.wdata)) stable = 1'b0;
      if (mem_read || mem_write) hi++;
    end
    chk("mem_stable", LW'(stable), LW'(1));
    mem_resp  = 1'b1;
    mem_rdata = line;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = ~line;
    if (cur.rd) begin
      if (cur.is_d) exp_d_rdata = line;
      else          exp_i_rdata = line;
    end
    chk("resp_granted", LW'(cur.is_d ? d_resp : i_resp), LW'(1));
    chk("resp_other", LW'(cur.is_d ? i_resp : d_resp), LW'(0));
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("mem_drop", LW'({mem_read, mem_write}), LW'(0));
    chk("mem_high_cycles", LW'(hi), LW'(lat));
    if (drop) begin
      if (cur.is_d) begin d_read = 1'b0; d_write = 1'b0; end
      else          begin i_read = 1'b0; i_write = 1'b0; end
    end
    @(negedge clk);
    chk("resp_clear", LW'({i_resp, d_resp}), LW'(0));
    chk("release_low", LW'({mem_read, mem_write}), LW'(0));
    chk("proto_rd_wr", LW'((i_read & i_write) | (d_read & d_write)), LW'(0));
  endtask

  initial begin
    int low;
    int ic, dc;
    logic [LW-1:0] line;

    rst = 1'b1;
    i_address = '0; i_read = 1'b0; i_write = 1'b0; i_wdata = '0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_op", LW'({mem_read, mem_write}), LW'(0));
    chk("rst_resp", LW'({i_resp, d_resp}), LW'(0));
    chk("rst_mem_address", LW'(mem_address), LW'(0));
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rdata", i_rdata | d_rdata, '0);

    // I read, 8-cycle adaptor latency
    i_address = 32'h0000_1000; i_read = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0000_1000, '0));
    wait_grant(low);
    finish(8, {32{8'hA5}}, 1'b1);
    chk("t1_i_resp_cnt", LW'(i_resp_cnt), LW'(1));
    chk("t1_d_resp_cnt", LW'(d_resp_cnt), LW'(0));

    // D write, 4-cycle latency
    d_address = 32'h0000_2040; d_wdata = {16{16'h1234}}; d_write = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_2040, {16{16'h1234}}));
    wait_grant(low);
    finish(4, {32{8'h3C}}, 1'b1);
    chk("t2_d_resp_cnt", LW'(d_resp_cnt), LW'(1));

    // Simultaneous reads after reset: I first, then D after 2 idle cycles
    do_reset();
    i_address = 32'h0000_1100; d_address = 32'h0000_2200;
    i_read = 1'b1; d_read = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0000_1100, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_2200, '0));
    wait_grant(low);
    finish(3, {8{32'h1111_0001}}, 1'b1);
    wait_grant(low);
    chk("turnaround_low_cycles", LW'(2 + low), LW'(2));
    finish(2, {8{32'h2222_0002}}, 1'b1);

    // Continuous contention: strict alternation
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 6; k++)
      exp_q.push_back(mk(k[0], 1'b1, k[0] ? 32'h0000_2200 : 32'h0000_1100, '0));
    for (int k = 0; k < 6; k++) begin
      line = {8{$urandom}};
      wait_grant(low);
      finish(2 + (k % 3), line, k >= 4);
    end

    // D arrives while I is busy and moves its address before being granted
    ic = i_resp_cnt; dc = d_resp_cnt;
    i_address = 32'h0000_4000; i_read = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0000_4000, '0));
    wait_grant(low);
    d_address = 32'h0000_5000; d_read = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_5080, '0));
    fork
      begin
        @(negedge clk);
        @(negedge clk);
        d_address = 32'h0000_5080;
      end
    join_none
    finish(5, {8{32'hCAFE_0044}}, 1'b1);
    wait_grant(low);
    finish(3, {8{32'hBEEF_0055}}, 1'b1);
    chk("busy_i_resp_cnt", LW'(i_resp_cnt - ic), LW'(1));
    chk("busy_d_resp_cnt", LW'(d_resp_cnt - dc), LW'(1));

    // Reset in the middle of a transfer
    ic = i_resp_cnt; dc = d_resp_cnt;
    i_address = 32'h0000_3000; i_read = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0000_3000, '0));
    wait_grant(low);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mem_op", LW'({mem_read, mem_write}), LW'(0));
    chk("midrst_mem_address", LW'(mem_address), LW'(0));
    chk("midrst_rdata", i_rdata | d_rdata, '0);
    chk("midrst_resp", LW'({i_resp, d_resp}), LW'(0));
    exp_i_rdata = '0; exp_d_rdata = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_resp", LW'((i_resp_cnt - ic) + (d_resp_cnt - dc)), LW'(0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0000_3000, '0));
    wait_grant(low);
    finish(3, {8{32'h7777_0077}}, 1'b1);
    chk("postrst_i_resp_cnt", LW'(i_resp_cnt - ic), LW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
